// File: rtl/oled_iic_pkg.sv
// Shared definitions for the SSD1306 I2C command writer.
package oled_iic_pkg;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        IDLE,
        START,
        BYTE,
        ACK,
        STOP,
        DONE
    } iic_state_e;

    // Panel address (write) and control bytes used by the upstream generators
    localparam logic [7:0] OLED_ADDR = 8'h78;
    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;

    // Quarter phases within one SCL period
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/iic_clk_div.sv
// Quarter-period tick generator: one-cycle pulse every QDIV cycles while run is high.
module iic_clk_div #(
    parameter int unsigned QDIV = 31
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = (QDIV > 1) ? $clog2(QDIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(QDIV - 1));

    // Free-running quarter counter, held at zero while the writer is idle
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (!run) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/oled_iic_writer.sv
// Serialises one 24-bit {addr, control, data} word as a single I2C write to the OLED panel.
module oled_iic_writer
    import oled_iic_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ = 50_000_000,
    parameter int unsigned SCL_FREQ     = 400_000,
    parameter int unsigned QDIV         = SYS_CLK_FREQ / (SCL_FREQ * 4)
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        write_req,
    input  logic [23:0] write_data,
    output logic        write_done,
    output logic        busy,
    output logic        ack_err,
    output logic        iic_scl,
    inout  wire         iic_sda
);

    if (QDIV < 2) begin : g_qdiv_check
        $error("oled_iic_writer: QDIV must be at least 2");
    end

    iic_state_e  r_state, w_state_d;
    logic [1:0]  r_phase, w_phase_d;
    logic [2:0]  r_bit_cnt, w_bit_cnt_d;
    logic [1:0]  r_byte_cnt, w_byte_cnt_d;
    logic [23:0] r_shift, w_shift_d;
    logic        r_ack_err, w_ack_err_d;
    logic        r_scl, w_scl_d;
    logic        r_sda_oe, w_sda_oe_d;
    logic        w_run, w_tick, w_last_q;

    assign w_run = (r_state != IDLE);

    iic_clk_div #(
        .QDIV (QDIV)
    ) u_clk_div (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .run     (w_run),
        .tick    (w_tick)
    );

    // State and datapath registers; line drivers are registered so the pins never glitch
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_phase    <= Q0;
            r_bit_cnt  <= 3'd7;
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
            r_ack_err  <= 1'b0;
            r_scl      <= 1'b1;
            r_sda_oe   <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_phase    <= w_phase_d;
            r_bit_cnt  <= w_bit_cnt_d;
            r_byte_cnt <= w_byte_cnt_d;
            r_shift    <= w_shift_d;
            r_ack_err  <= w_ack_err_d;
            r_scl      <= w_scl_d;
            r_sda_oe   <= w_sda_oe_d;
        end
    end

    // Next-state sequencing, advanced only on quarter ticks
    always_comb begin
        w_state_d    = r_state;
        w_phase_d    = r_phase;
        w_bit_cnt_d  = r_bit_cnt;
        w_byte_cnt_d = r_byte_cnt;
        w_shift_d    = r_shift;
        w_ack_err_d  = r_ack_err;
        w_last_q     = w_tick && (r_phase == Q3);
        if (w_tick) begin
            w_phase_d = r_phase + 2'd1;
        end
        unique case (r_state)
            IDLE: begin
                w_phase_d = Q0;
                if (write_req) begin
                    w_shift_d    = write_data;
                    w_ack_err_d  = 1'b0;
                    w_bit_cnt_d  = 3'd7;
                    w_byte_cnt_d = 2'd0;
                    w_state_d    = START;
                end
            end
            START: begin
                if (w_last_q) w_state_d = BYTE;
            end
            BYTE: begin
                if (w_last_q) begin
                    w_shift_d = {r_shift[22:0], 1'b0};
                    if (r_bit_cnt == 3'd0) begin
                        w_state_d = ACK;
                    end else begin
                        w_bit_cnt_d = r_bit_cnt - 3'd1;
                    end
                end
            end
            ACK: begin
                // Slave has held SDA since Q0, so sampling on entry to Q2 is safe
                if (w_tick && (r_phase == Q1) && (iic_sda !== 1'b0)) begin
                    w_ack_err_d = 1'b1;
                end
                if (w_last_q) begin
                    if (r_ack_err || (r_byte_cnt == 2'd2)) begin
                        w_state_d = STOP;
                    end else begin
                        w_byte_cnt_d = r_byte_cnt + 2'd1;
                        w_bit_cnt_d  = 3'd7;
                        w_state_d    = BYTE;
                    end
                end
            end
            STOP: begin
                if (w_last_q) w_state_d = DONE;
            end
            DONE: begin
                w_phase_d = Q0;
                w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Line levels for the upcoming quarter; SDA only moves while SCL is low except START/STOP
    always_comb begin
        w_scl_d    = 1'b1;
        w_sda_oe_d = 1'b0;
        unique case (w_state_d)
            START: begin
                w_scl_d    = (w_phase_d != Q3);
                w_sda_oe_d = (w_phase_d == Q2) || (w_phase_d == Q3);
            end
            BYTE: begin
                w_scl_d    = (w_phase_d == Q1) || (w_phase_d == Q2);
                w_sda_oe_d = ~w_shift_d[23];
            end
            ACK: begin
                w_scl_d    = (w_phase_d == Q1) || (w_phase_d == Q2);
                w_sda_oe_d = 1'b0;
            end
            STOP: begin
                w_scl_d    = (w_phase_d != Q0);
                w_sda_oe_d = (w_phase_d == Q0) || (w_phase_d == Q1);
            end
            default: begin
                w_scl_d    = 1'b1;
                w_sda_oe_d = 1'b0;
            end
        endcase
    end

    assign iic_scl    = r_scl;
    assign iic_sda    = r_sda_oe ? 1'b0 : 1'bz;
    assign write_done = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign ack_err    = r_ack_err;

endmodule

// File: tb/tb_oled_iic_writer.sv
// Self-checking bench: table-driven transfers plus back-to-back, reset and small-divider cases.
module tb_oled_iic_writer;

    localparam int Q = 31;

    typedef struct {
        logic [23:0] word;
        bit          nack;
        int          lat;
        logic        err;
        int          nbytes;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_req = 1'b0;
    logic [23:0] write_data = 24'd0;
    logic        write_done, busy, ack_err, iic_scl;
    wire         iic_sda;
    logic        slv_drive = 1'b0;

    logic        req2 = 1'b0;
    logic [23:0] data2 = 24'd0;
    logic        done2, busy2, err2, scl2;
    wire         sda2;
    logic        drv2 = 1'b0;

    pullup (iic_sda);
    pullup (sda2);
    assign iic_sda = slv_drive ? 1'b0 : 1'bz;
    assign sda2    = drv2 ? 1'b0 : 1'bz;

    always #5 sys_clk = ~sys_clk;

    oled_iic_writer u_dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .write_req  (write_req),
        .write_data (write_data),
        .write_done (write_done),
        .busy       (busy),
        .ack_err    (ack_err),
        .iic_scl    (iic_scl),
        .iic_sda    (iic_sda)
    );

    oled_iic_writer #(
        .SYS_CLK_FREQ (8),
        .SCL_FREQ     (1)
    ) u_dut_q2 (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .write_req  (req2),
        .write_data (data2),
        .write_done (done2),
        .busy       (busy2),
        .ack_err    (err2),
        .iic_scl    (scl2),
        .iic_sda    (sda2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor and ACKing slave for the main instance
    bit         mon_en = 1'b0;
    bit         nack_addr = 1'b0;
    logic       p_scl = 1'b1, p_sda = 1'b1;
    int         lvl_len = 0;
    int         n_start = 0, n_stop = 0;
    int         bitcnt = 0, txn_bytes = 0;
    bit         acking = 1'b0;
    logic [7:0] cur = 8'd0;
    logic [7:0] got[$];

    always @(negedge sys_clk) begin
        if (!mon_en) begin
            lvl_len   = 0;
            bitcnt    = 0;
            acking    = 1'b0;
            slv_drive = 1'b0;
        end else begin
            if (p_scl && iic_scl && p_sda && !iic_sda) begin
                n_start++;
                bitcnt    = 0;
                txn_bytes = 0;
                acking    = 1'b0;
                slv_drive = 1'b0;
            end else if (p_scl && iic_scl && !p_sda && iic_sda) begin
                n_stop++;
            end
            if (iic_scl !== p_scl) begin
                n_checks++;
                if (lvl_len < 2 * Q) begin
                    n_errors++;
                    $display("FAIL scl_level_time: got %0d cycles expected >= %0d", lvl_len, 2 * Q);
                end
                lvl_len = 1;
                if (iic_scl) begin
                    if (bitcnt < 8) begin
                        cur = {cur[6:0], iic_sda};
                        bitcnt++;
                        if (bitcnt == 8) begin
                            got.push_back(cur);
                            txn_bytes++;
                        end
                    end
                end else begin
                    if (acking) begin
                        slv_drive = 1'b0;
                        acking    = 1'b0;
                        bitcnt    = 0;
                    end else if (bitcnt == 8) begin
                        acking    = 1'b1;
                        slv_drive = !(nack_addr && txn_bytes == 1);
                    end
                end
            end else begin
                lvl_len++;
            end
        end
        p_scl = iic_scl;
        p_sda = iic_sda;
    end

    // Minimal ACKing slave for the QDIV=2 instance: ACK after every 8 data falls
    logic p_scl2 = 1'b1, p_sda2 = 1'b1;
    int   f2 = 0;
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            drv2 = 1'b0;
            f2   = 0;
        end else if (p_scl2 && scl2 && p_sda2 && !sda2) begin
            drv2 = 1'b0;
            f2   = 0;
        end else if (p_scl2 && !scl2) begin
            drv2 = (f2 % 9 == 8);
            f2++;
        end
        p_scl2 = scl2;
        p_sda2 = sda2;
    end

    // One transfer on the main instance with full result checking
    task automatic run_vec(input vec_t v, input string tag);
        int  lat;
        bit  seen;
        int  s0, t0;
        logic [7:0] exp_b[3];
        exp_b[0] = v.word[23:16];
        exp_b[1] = v.word[15:8];
        exp_b[2] = v.word[7:0];
        @(negedge sys_clk);
        nack_addr  = v.nack;
        write_data = v.word;
        write_req  = 1'b1;
        s0 = n_start;
        t0 = n_stop;
        got.delete();
        @(posedge sys_clk);
        #1;
        write_req  = 1'b0;
        write_data = 24'hDEAD_BE;
        check({tag, " busy_at_accept"}, busy, 1'b1);
        check({tag, " ack_err_cleared"}, ack_err, 1'b0);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 5000) begin
            @(posedge sys_clk);
            lat++;
            #1;
            if (write_done) seen = 1'b1;
        end
        check({tag, " latency"}, lat, v.lat);
        check({tag, " ack_err"}, ack_err, v.err);
        check({tag, " busy_at_done"}, busy, 1'b1);
        @(posedge sys_clk);
        #1;
        check({tag, " done_single_cycle"}, write_done, 1'b0);
        check({tag, " busy_after_done"}, busy, 1'b0);
        repeat (3) @(posedge sys_clk);
        check({tag, " start_count"}, n_start - s0, 1);
        check({tag, " stop_count"}, n_stop - t0, 1);
        check({tag, " byte_count"}, got.size(), v.nbytes);
        for (int i = 0; i < v.nbytes; i++) begin
            check({tag, " byte"}, (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, exp_b[i]);
        end
    endtask

    vec_t vecs[4];
    logic [23:0] words[3];

    initial begin
        vecs[0] = '{24'h78_00_B3, 1'b0, 3597, 1'b0, 3};
        vecs[1] = '{24'h78_40_3C, 1'b1, 1365, 1'b1, 1};
        vecs[2] = '{24'h78_00_06, 1'b0, 3597, 1'b0, 3};
        vecs[3] = '{24'h3C_A5_5A, 1'b0, 3597, 1'b0, 3};
        words[0] = 24'h78_00_B3;
        words[1] = 24'h78_00_06;
        words[2] = 24'h78_40_3C;

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst scl", iic_scl, 1'b1);
        check("rst sda", iic_sda, 1'b1);
        check("rst write_done", write_done, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst ack_err", ack_err, 1'b0);
        @(negedge sys_clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(posedge sys_clk);

        // Directed vectors, including NACK on address and recovery
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back with write_req held and the word updated on each write_done
        begin
            int ndone, cyc, s0, t0;
            @(negedge sys_clk);
            nack_addr  = 1'b0;
            got.delete();
            s0 = n_start;
            t0 = n_stop;
            ndone = 0;
            cyc = 0;
            write_data = words[0];
            write_req  = 1'b1;
            while (ndone < 3 && cyc < 12000) begin
                @(negedge sys_clk);
                cyc++;
                if (write_done) begin
                    ndone++;
                    if (ndone < 3) write_data = words[ndone];
                    else write_req = 1'b0;
                end
            end
            repeat (20) begin
                @(negedge sys_clk);
                if (write_done) ndone++;
            end
            check("b2b done_count", ndone, 3);
            check("b2b busy_idle", busy, 1'b0);
            check("b2b start_count", n_start - s0, 3);
            check("b2b stop_count", n_stop - t0, 3);
            check("b2b byte_count", got.size(), 9);
            for (int i = 0; i < 9; i++) begin
                logic [23:0] w;
                logic [7:0]  e;
                w = words[i / 3];
                e = (i % 3 == 0) ? w[23:16] : (i % 3 == 1) ? w[15:8] : w[7:0];
                check("b2b byte", (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, e);
            end
        end

        // Reset during bit 4 of the control byte (0x40: that bit is 0)
        begin
            int ndone;
            @(negedge sys_clk);
            write_data = 24'h78_40_B3;
            write_req  = 1'b1;
            @(posedge sys_clk);
            #1;
            write_req = 1'b0;
            repeat (53 * Q + 1 + Q / 2 - 1) @(posedge sys_clk);
            #2;
            check("mid scl_high", iic_scl, 1'b1);
            check("mid sda_bit4", iic_sda, 1'b0);
            mon_en = 1'b0;
            rst_n  = 1'b0;
            #1;
            check("arst scl", iic_scl, 1'b1);
            check("arst sda", iic_sda, 1'b1);
            check("arst busy", busy, 1'b0);
            check("arst write_done", write_done, 1'b0);
            repeat (3) @(negedge sys_clk);
            rst_n = 1'b1;
            ndone = 0;
            repeat (200) begin
                @(negedge sys_clk);
                if (write_done) ndone++;
            end
            check("arst no_done", ndone, 0);
            check("arst busy_after", busy, 1'b0);
            mon_en = 1'b1;
            repeat (4) @(posedge sys_clk);
            run_vec(vecs[0], "post_rst");
        end

        // QDIV = 2 instance
        begin
            int  lat;
            bit  seen;
            @(negedge sys_clk);
            data2 = 24'h78_00_B3;
            req2  = 1'b1;
            @(posedge sys_clk);
            #1;
            req2 = 1'b0;
            lat  = 0;
            seen = 1'b0;
            while (!seen && lat < 1000) begin
                @(posedge sys_clk);
                lat++;
                #1;
                if (done2) seen = 1'b1;
            end
            check("q2 latency", lat, 233);
            check("q2 ack_err", err2, 1'b0);
            @(posedge sys_clk);
            #1;
            check("q2 done_single_cycle", done2, 1'b0);
            check("q2 busy_after", busy2, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
